// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans an NROWS x NCOLS matrix keypad one row at a time, debounces the first
// key found, and reports it as an encoded key number. Only one key is tracked
// at a time (single-key rollover): while a key is held, every other key is
// ignored until that key's release has debounced.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous reset, active low
//   cols_n     in   [NCOLS]  raw column inputs, low = key closed in driven row
//   rows_n     out  [NROWS]  row drives, exactly one bit low at all times
//   key_code   out  [$clog2(NROWS*NCOLS)]  row*NCOLS + col of last accepted key
//   key_valid  out  one-cycle strobe when a key is accepted
//   key_held   out  high from accept until the release has debounced
//
// Optional feature (define KEYPAD_AUTOREPEAT_EN):
//   While a key stays held, key_valid re-pulses with the same key_code
//   REPEAT_DELAY clocks after the accept strobe and then every REPEAT_PERIOD
//   clocks. The repeat count pauses while a release is being debounced and
//   clears when the scanner goes back to scanning.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NCOLS-1:0]                 cols_n,
  output logic [NROWS-1:0]                 rows_n,
  output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
  output logic                             key_valid,
  output logic                             key_held
);

  localparam int ROW_W    = $clog2(NROWS);
  localparam int COL_W    = $clog2(NCOLS);
  localparam int CODE_W   = $clog2(NROWS*NCOLS);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W    = $clog2(REP_MAX + 1);

  localparam logic [ROW_W-1:0]    ROW_LAST        = ROW_W'(NROWS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST     = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST        = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_MAX         = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0]    REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]    REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0]    REP_SAT         = REP_W'(REP_MAX);
  localparam logic [CODE_W-1:0]   NCOLS_CODE      = CODE_W'(NCOLS);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t              state;
  logic [NCOLS-1:0]    cols_meta;
  logic [NCOLS-1:0]    cols_sync;
  logic [ROW_W-1:0]    row_idx;
  logic [COL_W-1:0]    col_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic [REP_W-1:0]    rep_cnt;
  logic                rep_armed;

  logic                any_active;
  logic [COL_W-1:0]    low_col;
  logic                col_active;
  logic [ROW_W-1:0]    next_row;
  logic [CODE_W-1:0]   accept_code;

  // One-hot-low row drive pattern for a given row index.
  function automatic logic [NROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
    logic [NROWS-1:0] drive;
    drive    = '1;
    drive[r] = 1'b0;
    return drive;
  endfunction

  // Column inputs are asynchronous to clk; the idle level (all ones) is what
  // the pull-ups present when nothing is pressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cols_meta <= '1;
      cols_sync <= '1;
    end else begin
      cols_meta <= cols_n;
      cols_sync <= cols_meta;
    end
  end

  // Scanning from the top index down leaves the lowest active column last,
  // which gives the lowest-column-wins priority.
  always_comb begin
    any_active = 1'b0;
    low_col    = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (!cols_sync[i]) begin
        any_active = 1'b1;
        low_col    = COL_W'(i);
      end
    end
  end

  assign col_active  = ~cols_sync[col_idx];
  assign next_row    = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
  assign accept_code = CODE_W'(row_idx) * NCOLS_CODE + CODE_W'(col_idx);

  // Main scanner FSM. rows_n is registered alongside row_idx so the row drive
  // never glitches; every exit back to SCAN moves on to the following row so
  // a stuck or just-released key cannot monopolise the scan.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SCAN;
      row_idx    <= '0;
      col_idx    <= '0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      rep_cnt    <= '0;
      rep_armed  <= 1'b0;
      rows_n     <= row_drive('0);
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (settle_cnt >= SETTLE_LAST) begin
            settle_cnt <= '0;
            if (any_active) begin
              col_idx <= low_col;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_idx <= next_row;
              rows_n  <= row_drive(next_row);
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!col_active) begin
            state      <= SCAN;
            row_idx    <= next_row;
            rows_n     <= row_drive(next_row);
            settle_cnt <= '0;
            deb_cnt    <= '0;
          end else if (deb_cnt >= DEB_LAST) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive active one.
            deb_cnt   <= DEB_MAX;
            key_code  <= accept_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            state     <= HELD;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!col_active) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end else if (AUTOREPEAT) begin
            // rep_armed marks that the first (long) delay has elapsed.
            if ((!rep_armed && rep_cnt >= REP_DELAY_LAST) ||
                ( rep_armed && rep_cnt >= REP_PERIOD_LAST)) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_armed <= 1'b1;
            end else if (rep_cnt != REP_SAT) begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end

        RELEASE: begin
          if (col_active) begin
            state <= HELD;
          end else if (deb_cnt >= DEB_LAST) begin
            key_held   <= 1'b0;
            rep_cnt    <= '0;
            rep_armed  <= 1'b0;
            deb_cnt    <= '0;
            settle_cnt <= '0;
            row_idx    <= next_row;
            rows_n     <= row_drive(next_row);
            state      <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: begin
          state      <= SCAN;
          row_idx    <= '0;
          rows_n     <= row_drive('0);
          settle_cnt <= '0;
          deb_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner with default parameters
// (4x4, SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8). A behavioural keypad model pulls
// a column low whenever a pressed key sits in the currently driven row.
// Defining KEYPAD_AUTOREPEAT_EN for the whole build also switches the
// expected repeat behaviour of the long-hold sequence.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols_n;
  logic [3:0] rows_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  bit pressed [NR][NC];

  int total = 0;
  int bad = 0;
  int valid_count = 0;

  typedef struct {
    int         row;
    int         col;
    int         code;
    logic [3:0] rows;
  } key_vec_t;

  key_vec_t vecs[5];

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .cols_n    (cols_n),
    .rows_n    (rows_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Keypad matrix: a closed key shorts its column to its row line.
  always_comb begin
    cols_n = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r][c] && !rows_n[r]) cols_n[c] = 1'b0;
  end

  // Strobe counter, sampled well after the active edge.
  always begin
    @(posedge clk);
    #2;
    if (key_valid === 1'b1) valid_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input bit down);
    pressed[r][c] = down;
  endtask

  task automatic stepClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input string name, input int budget);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid_seen"}, key_valid, 1);
  endtask

  task automatic waitHeldLow(input string name, input int budget, output int n);
    n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_held_dropped"}, key_held, 0);
  endtask

  initial begin
    logic [3:0] seq[5];
    logic [3:0] cur;
    int n, run, base, cyc, frozen_bad, cnt, drop;
    int offs[$];

    vecs[0] = '{row: 0, col: 0, code: 0,  rows: 4'b1110};
    vecs[1] = '{row: 1, col: 2, code: 6,  rows: 4'b1101};
    vecs[2] = '{row: 3, col: 3, code: 15, rows: 4'b0111};
    vecs[3] = '{row: 0, col: 3, code: 3,  rows: 4'b1110};
    vecs[4] = '{row: 3, col: 0, code: 12, rows: 4'b0111};

    seq[0] = 4'b1101;
    seq[1] = 4'b1011;
    seq[2] = 4'b0111;
    seq[3] = 4'b1110;
    seq[4] = 4'b1101;

    // Reset state
    reset = 1'b0;
    stepClk(3);
    checkOutput("reset_rows_n", rows_n, 4'b1110);
    checkOutput("reset_key_valid", key_valid, 0);
    checkOutput("reset_key_held", key_held, 0);
    checkOutput("reset_key_code", key_code, 0);
    reset = 1'b1;

    // Idle scan: each row held SETTLE_CYCLES clocks, in order, wrapping.
    cur = rows_n;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (rows_n === cur && n < 12) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("scan_row_%0d", i), rows_n, seq[i]);
      cur = rows_n;
      run = 0;
      while (rows_n === cur && run < 12) begin
        @(negedge clk);
        run++;
      end
      checkOutput($sformatf("scan_run_%0d", i), run, 4);
    end
    checkOutput("idle_no_valid", valid_count, 0);

    // Table of single clean presses
    for (int i = 0; i < 5; i++) begin
      base = valid_count;
      applyStimulus(vecs[i].row, vecs[i].col, 1'b1);
      waitValid($sformatf("vec%0d", i), 100);
      checkOutput($sformatf("vec%0d_code", i), key_code, vecs[i].code);
      checkOutput($sformatf("vec%0d_held", i), key_held, 1);
      checkOutput($sformatf("vec%0d_rows", i), rows_n, vecs[i].rows);
      stepClk(40);
      checkOutput($sformatf("vec%0d_one_strobe", i), valid_count, base + 1);
      checkOutput($sformatf("vec%0d_rows_frozen", i), rows_n, vecs[i].rows);
      checkOutput($sformatf("vec%0d_still_held", i), key_held, 1);
      applyStimulus(vecs[i].row, vecs[i].col, 1'b0);
      waitHeldLow($sformatf("vec%0d", i), 40, cyc);
      checkOutput($sformatf("vec%0d_release_window", i), (cyc >= 9 && cyc <= 12), 1);
      checkOutput($sformatf("vec%0d_code_kept", i), key_code, vecs[i].code);
      stepClk(2);
    end

    // Long hold at row 2 col 1 (with autorepeat: strobes at +64, +80, ...)
    base = valid_count;
    applyStimulus(2, 1, 1'b1);
    waitValid("long", 100);
    checkOutput("long_code", key_code, 9);
    frozen_bad = 0;
    offs.delete();
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (rows_n !== 4'b1011) frozen_bad++;
      if (key_valid === 1'b1) offs.push_back(k);
    end
    checkOutput("long_rows_frozen", frozen_bad, 0);
    checkOutput("long_held", key_held, 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    checkOutput("long_repeat_count", offs.size(), 9);
    checkOutput("long_first_repeat", (offs.size() > 0) ? offs[0] : -1, 64);
    checkOutput("long_second_repeat", (offs.size() > 1) ? offs[1] : -1, 80);
`else
    checkOutput("long_repeat_count", offs.size(), 0);
    checkOutput("long_one_strobe", valid_count, base + 1);
`endif
    applyStimulus(2, 1, 1'b0);
    waitHeldLow("long", 40, cyc);
    checkOutput("long_release_window", (cyc >= 9 && cyc <= 12), 1);
    stepClk(2);

    // Bouncing contact: toggles every 3 clocks, then settles closed.
    base = valid_count;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2, 1, (i % 2) == 0);
      stepClk(3);
    end
    checkOutput("bounce_no_strobe", valid_count, base);
    applyStimulus(2, 1, 1'b1);
    waitValid("bounce", 60);
    checkOutput("bounce_code", key_code, 9);
    stepClk(10);
    checkOutput("bounce_one_strobe", valid_count, base + 1);
    applyStimulus(2, 1, 1'b0);
    waitHeldLow("bounce", 40, cyc);
    stepClk(2);

    // Release glitch: 4 open clocks while held must not end the press.
    applyStimulus(0, 2, 1'b1);
    waitValid("glitch", 100);
    checkOutput("glitch_code", key_code, 2);
    stepClk(5);
    base = valid_count;
    drop = 0;
    applyStimulus(0, 2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (key_held !== 1'b1) drop++;
    end
    applyStimulus(0, 2, 1'b1);
    repeat (20) begin
      @(negedge clk);
      if (key_held !== 1'b1) drop++;
    end
    checkOutput("glitch_held_stays", drop, 0);
    checkOutput("glitch_no_new_strobe", valid_count, base);
    applyStimulus(0, 2, 1'b0);
    waitHeldLow("glitch", 40, cyc);
    stepClk(2);

    // Two keys in one row: lowest column wins; another row is ignored.
    base = valid_count;
    applyStimulus(1, 3, 1'b1);
    applyStimulus(1, 0, 1'b1);
    waitValid("multi", 100);
    checkOutput("multi_code", key_code, 4);
    applyStimulus(3, 2, 1'b1);
    stepClk(40);
    checkOutput("rollover_code", key_code, 4);
    checkOutput("rollover_rows", rows_n, 4'b1101);
    checkOutput("rollover_one_strobe", valid_count, base + 1);
    applyStimulus(3, 2, 1'b0);
    applyStimulus(1, 3, 1'b0);
    applyStimulus(1, 0, 1'b0);
    waitHeldLow("multi", 40, cyc);
    stepClk(2);

    // Reset while debouncing
    base = valid_count;
    applyStimulus(2, 1, 1'b1);
    cnt = 0;
    n = 0;
    while (cnt < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (rows_n === 4'b1011) cnt++;
      else cnt = 0;
    end
    checkOutput("rst_reached_debounce", cnt, 6);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_rows_n", rows_n, 4'b1110);
    checkOutput("rst_key_held", key_held, 0);
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_no_strobe", valid_count, base);
    applyStimulus(2, 1, 1'b0);
    stepClk(2);
    reset = 1'b1;
    stepClk(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
